// File: rtl/rx_fifo_device.sv
// Memory-mapped receive FIFO: producer pushes bytes via valid/ready, the CPU
// pops DATA and reads/writes STATUS/CTRL and THRESH with zero-latency loads.
module rx_fifo_device #(
  parameter int unsigned DEPTH = 8,
  parameter logic [31:0] BASE  = 32'hffff0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rd_data,
  output logic        RxAddress,
  output logic        RxInterrupt,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  DEPTH8     = 8'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          ie;
  logic [7:0]    thresh;

  logic       sel_data;
  logic       sel_ctrl;
  logic       sel_thresh;
  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic [7:0] count8;
  logic [7:0] thresh_next;
  logic       unused_bits;

  assign unused_bits = ^{address[1:0], wr_data[31:8]};

  assign RxAddress  = (address[31:4] == BASE[31:4]) && (address[3:2] != 2'b11);
  assign sel_data   = RxAddress && (address[3:2] == 2'b00);
  assign sel_ctrl   = RxAddress && (address[3:2] == 2'b01);
  assign sel_thresh = RxAddress && (address[3:2] == 2'b10);

  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);
  assign count8 = 8'(count);

  // Room is judged on registered count only; a same-cycle pop does not free a slot.
  assign in_ready = ~full && ~reset;
  assign push     = in_valid && in_ready;
  assign pop      = MemRead && sel_data && ~empty;

  assign RxInterrupt = ie && (count8 >= thresh);

  always_comb begin
    if (wr_data[7:0] == 8'd0) begin
      thresh_next = 8'd1;
    end else if (wr_data[7:0] > DEPTH8) begin
      thresh_next = DEPTH8;
    end else begin
      thresh_next = wr_data[7:0];
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel_data && !empty) begin
      rd_data = {24'd0, mem[rd_ptr]};
    end else if (sel_ctrl) begin
      rd_data = {16'd0, count8, 5'd0, ie, full, empty};
    end else if (sel_thresh) begin
      rd_data = {24'd0, thresh};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ie     <= 1'b0;
      thresh <= 8'd1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (MemWrite && sel_ctrl)   ie     <= wr_data[0];
      if (MemWrite && sel_thresh) thresh <= thresh_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_rx_fifo_device.sv
// Randomized and directed bench for rx_fifo_device, checked every cycle
// against a queue-based model of the register window and interrupt.
module tb_rx_fifo_device;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hffff0010;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_THR  = BASE + 32'd8;
  localparam logic [31:0] A_GAP  = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rd_data;
  logic        RxAddress;
  logic        RxInterrupt;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;

  always #5 clk = ~clk;

  rx_fifo_device #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .wr_data(wr_data),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .rd_data(rd_data),
    .RxAddress(RxAddress),
    .RxInterrupt(RxInterrupt),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0] q[$];
  logic       m_ie;
  logic [7:0] m_thr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return (a[31:4] == b[31:4]) && (a[3:2] != 2'b11);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    int n;
    n = q.size();
    case (a[3:2])
      2'b00:   return (n > 0) ? {24'd0, q[0]} : 32'd0;
      2'b01:   return {16'd0, 8'(n), 5'd0, m_ie, (n == int'(DEPTH)), (n == 0)};
      2'b10:   return {24'd0, m_thr};
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: drive, check combinational view of pre-edge state, then advance the model.
  task automatic cycle(input logic rst, input logic v, input logic [7:0] d, input logic rd,
                       input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic chk);
    logic pushed;
    logic popped;
    int   n;
    reset = rst; in_valid = v; in_data = d; MemRead = rd; MemWrite = wr;
    address = a; wr_data = wd;
    #3;
    n = q.size();
    if (chk) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !rst && (n < int'(DEPTH))});
      check("irq", {31'd0, RxInterrupt}, {31'd0, m_ie && (n >= int'(m_thr))});
      check("hit", {31'd0, RxAddress}, {31'd0, m_hit(a)});
      if (m_hit(a)) check("rd_data", rd_data, m_rd(a));
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ie  = 1'b0;
      m_thr = 8'd1;
    end else begin
      pushed = v && (n < int'(DEPTH));
      popped = rd && m_hit(a) && (a[3:2] == 2'b00) && (n > 0);
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(d);
      if (wr && m_hit(a)) begin
        if (a[3:2] == 2'b01) m_ie = wd[0];
        else if (a[3:2] == 2'b10)
          m_thr = (wd[7:0] == 8'd0) ? 8'd1 : ((int'(wd[7:0]) > int'(DEPTH)) ? 8'(DEPTH) : wd[7:0]);
      end
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] a);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, a, 32'd0, 1'b1);
  endtask

  task automatic push(input logic [7:0] d);
    cycle(1'b0, 1'b1, d, 1'b0, 1'b0, A_STAT, 32'd0, 1'b1);
  endtask

  task automatic pop();
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, A_DATA, 32'd0, 1'b1);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a, wd, 1'b1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rwd;
    int sel;

    m_ie  = 1'b0;
    m_thr = 8'd1;
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, A_DATA, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, A_STAT, 32'd0, 1'b1);

    idle(A_STAT); idle(A_THR); idle(A_DATA);

    push(8'h41); push(8'h42); push(8'h43);
    idle(A_STAT);
    pop(); pop(); pop(); pop();
    idle(A_STAT);

    for (int i = 0; i < int'(DEPTH); i++) push(8'(8'h50 + i));
    idle(A_STAT);
    push(8'hEE);
    idle(A_STAT);
    pop();
    idle(A_STAT);

    push(8'h60); push(8'h61);
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, A_DATA, 32'd0, 1'b1);
    for (int i = 0; i < 12; i++) pop();
    idle(A_STAT);

    store(A_STAT, 32'd1); store(A_THR, 32'd3);
    push(8'h71); push(8'h72);
    idle(A_STAT);
    push(8'h73);
    idle(A_STAT);
    pop();
    idle(A_STAT);
    store(A_THR, 32'd0);  idle(A_THR);
    store(A_THR, 32'd20); idle(A_THR);

    store(A_THR, 32'd2);
    push(8'h74); push(8'h75); push(8'h76);
    idle(A_STAT);
    cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, A_STAT, 32'd0, 1'b1);
    idle(A_STAT); idle(A_DATA); idle(A_THR);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, A_GAP, 32'd0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       ra = A_DATA;
        1:       ra = A_STAT;
        2:       ra = A_THR;
        3:       ra = A_GAP;
        default: ra = $urandom;
      endcase
      rwd = (sel == 2) ? 32'($urandom_range(0, 20)) : $urandom;
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0), ra, rwd, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
